// File: rtl/ets_sweep_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ets_sweep_pkg
// Shared definitions for the ETS sweep sequencer: FSM state encoding, the
// word stored when a sampler run times out, and the point-count clamp helper.
// ---------------------------------------------------------------------------
package ets_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_WAIT   = 2'd3
  } sweep_state_t;

  localparam logic [31:0] TIMEOUT_SENTINEL = 32'hFFFF_FFFF;

  // Limits a requested point count to the number of buffer entries.
  function automatic logic [31:0] STEP_COUNT_MAX(input logic [31:0] req,
                                                 input logic [31:0] depth);
    logic [31:0] res;
    if (req > depth) begin
      res = depth;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/ets_sweep_sequencer_if.sv
// ---------------------------------------------------------------------------
// ets_sweep_if
// Bundles the sweep sequencer's configuration, clock-generator, sampler and
// buffer read-back signals.
//   master : the sequencer side (drives timing_control, request_run, rd_data,
//            busy, done, error, points_captured)
//   slave  : the environment side (drives start/abort, sweep setup, locked,
//            sampler result and rd_addr)
// Parameter DEPTH must match the sequencer's DEPTH.
// ---------------------------------------------------------------------------
interface ets_sweep_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          start;
  logic          abort;
  logic [31:0]   phase_start;
  logic [31:0]   phase_step;
  logic [AW:0]   step_count;
  logic [31:0]   timing_control;
  logic          locked;
  logic          request_run;
  logic          result_ready;
  logic [31:0]   sampler_result;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   points_captured;

  modport master (
    input  start, abort, phase_start, phase_step, step_count,
    input  locked, result_ready, sampler_result, rd_addr,
    output timing_control, request_run, rd_data, busy, done, error,
    output points_captured
  );

  modport slave (
    output start, abort, phase_start, phase_step, step_count,
    output locked, result_ready, sampler_result, rd_addr,
    input  timing_control, request_run, rd_data, busy, done, error,
    input  points_captured
  );

endinterface

// File: rtl/ets_sweep_sequencer_ram.sv
// ---------------------------------------------------------------------------
// ets_result_ram
// Simple dual-port result buffer, DEPTH x 32.
//   clk, reset : clock, synchronous active-high reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   raddr_i, rdata_o       : registered read port, one-cycle latency; a read
//                            of the address written in the same cycle
//                            returns the old contents
// ---------------------------------------------------------------------------
module ets_result_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Write port; storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ets_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// ets_sweep_sequencer
// Steps the ETS clock generator through a series of phase words, fires one
// sampler run per point once the clock has settled and locked, and stores
// each result in an on-chip buffer for read-back.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : ets_sweep_if.master (setup, clock-generator timing control and
//           lock, sampler handshake, buffer read port, status)
// Optional feature: define ETS_SWEEP_TIMEOUT_EN to bound the wait for a
// sampler result to TIMEOUT_CYCLES; a timed-out point stores the sentinel
// word and raises the sticky error flag. Without it, error is tied low.
// ---------------------------------------------------------------------------
module ets_sweep_sequencer
  import ets_sweep_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  ets_sweep_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  sweep_state_t  state_q;
  logic [31:0]   tc_q;
  logic [31:0]   step_q;
  logic [AW:0]   count_q;
  logic [AW:0]   pcap_q;
  logic [AW-1:0] idx_q;
  logic [SW-1:0] settle_q;
  logic          req_q;
  logic          done_q;

  logic [AW:0]   clamp_d;
  logic          last_d;
  logic          wr_en_d;
  logic [31:0]   wr_data_d;

`ifdef ETS_SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          timed_out_d;
`endif

  assign clamp_d = (AW+1)'(STEP_COUNT_MAX(32'(bus.step_count), 32'(DEPTH)));
  assign last_d  = (({1'b0, idx_q} + (AW+1)'(1)) == count_q);

  // Buffer write request: a sampler result, or the sentinel when the wait expires.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_data_d = bus.sampler_result;
`ifdef ETS_SWEEP_TIMEOUT_EN
    timed_out_d = 1'b0;
`endif
    if (state_q == ST_WAIT) begin
      if (bus.result_ready) begin
        wr_en_d = 1'b1;
      end
`ifdef ETS_SWEEP_TIMEOUT_EN
      else if (tmo_q == TMO_LAST) begin
        wr_en_d     = 1'b1;
        wr_data_d   = TIMEOUT_SENTINEL;
        timed_out_d = 1'b1;
      end
`endif
      else begin
        wr_en_d = 1'b0;
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Sweep FSM with settle/timeout counters and the phase accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tc_q     <= 32'd0;
      step_q   <= 32'd0;
      count_q  <= '0;
      pcap_q   <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef ETS_SWEEP_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // abort is meaningless here, so start always wins
          if (bus.start) begin
            tc_q    <= bus.phase_start;
            step_q  <= bus.phase_step;
            count_q <= clamp_d;
            idx_q   <= '0;
            pcap_q  <= '0;
`ifdef ETS_SWEEP_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            if (clamp_d == '0) begin
              done_q <= 1'b1;
            end else begin
              done_q   <= 1'b0;
              settle_q <= '0;
              state_q  <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
          end else if (settle_q != SETTLE_LAST) begin
            settle_q <= settle_q + SW'(1);
          end else if (bus.locked) begin
            req_q   <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
`ifdef ETS_SWEEP_TIMEOUT_EN
          tmo_q <= '0;
`endif
        end
        ST_WAIT: begin
          // the point is stored even when abort arrives in the same cycle
          if (wr_en_d) begin
            pcap_q <= pcap_q + (AW+1)'(1);
          end
`ifdef ETS_SWEEP_TIMEOUT_EN
          if (timed_out_d) begin
            err_q <= 1'b1;
          end
`endif
          if (bus.abort) begin
            state_q <= ST_IDLE;
          end else if (wr_en_d) begin
            if (last_d) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              tc_q     <= tc_q + step_q;
              idx_q    <= idx_q + AW'(1);
              settle_q <= '0;
              state_q  <= ST_SETTLE;
            end
          end
`ifdef ETS_SWEEP_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  ets_result_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en_d),
    .waddr_i (idx_q),
    .wdata_i (wr_data_d),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.timing_control  = tc_q;
  assign bus.request_run     = req_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = done_q;
  assign bus.points_captured = pcap_q;
`ifdef ETS_SWEEP_TIMEOUT_EN
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_ets_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ets_sweep_sequencer
// Directed bench for the ETS sweep sequencer (DEPTH=8, SETTLE_CYCLES=4,
// TIMEOUT_CYCLES=100). Expected phase words and buffer contents are queued
// when each sweep is launched; independent monitors pop and compare them on
// every request_run pulse and every buffer read.
// ---------------------------------------------------------------------------
module tb_ets_sweep_sequencer;

  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic clk = 1'b0;
  logic reset;

  ets_sweep_if #(.DEPTH(DEPTH)) bus ();

  ets_sweep_sequencer #(
    .DEPTH          (DEPTH),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_tc_q [$];
  logic [31:0] exp_rd_q [$];
  bit          sampler_en = 1'b1;
  bit          rd_fire = 1'b0;
  bit          rd_pipe = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every request_run pulse must carry the next expected phase word.
  initial forever begin
    @(negedge clk);
    if (bus.request_run === 1'b1) begin
      if (exp_tc_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_request_run: got pulse with tc %h expected none",
                 bus.timing_control);
      end else begin
        check("request_run_phase", bus.timing_control, exp_tc_q.pop_front());
      end
    end
  end

  // Read pipeline marker: data for a read issued in one cycle is due the next.
  always @(posedge clk) rd_pipe <= rd_fire;

  // Monitor: compare buffer read data against queued expectations.
  initial forever begin
    @(negedge clk);
    if (rd_pipe) begin
      if (exp_rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_read: got %h expected no read", bus.rd_data);
      end else begin
        check("rd_data", bus.rd_data, exp_rd_q.pop_front());
      end
    end
  end

  // Sampler model: replies 5 cycles after request_run with the phase word.
  initial begin
    logic [31:0] ph;
    bus.result_ready   = 1'b0;
    bus.sampler_result = 32'd0;
    forever begin
      @(negedge clk);
      if (sampler_en && bus.request_run === 1'b1) begin
        ph = bus.timing_control;
        repeat (5) @(negedge clk);
        bus.result_ready   = 1'b1;
        bus.sampler_result = ph;
        @(negedge clk);
        bus.result_ready   = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the cycle after start (first busy cycle).
  task automatic start_sweep(input logic [31:0] ps, input logic [31:0] st,
                             input logic [AW:0] cnt);
    @(negedge clk);
    bus.phase_start = ps;
    bus.phase_step  = st;
    bus.step_count  = cnt;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, 32'(bus.done), 32'd1);
  endtask

  task automatic read_buf(input int a, input logic [31:0] e);
    @(negedge clk);
    bus.rd_addr = AW'(a);
    rd_fire     = 1'b1;
    exp_rd_q.push_back(e);
  endtask

  task automatic read_end();
    @(negedge clk);
    rd_fire = 1'b0;
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int stray;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.phase_start = 32'd0;
    bus.phase_step  = 32'd0;
    bus.step_count  = '0;
    bus.locked      = 1'b1;
    bus.rd_addr     = '0;
    tick(3);
    check("rst_timing_control", bus.timing_control, 32'd0);
    check("rst_request_run", 32'(bus.request_run), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_points", 32'(bus.points_captured), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    reset = 1'b0;

    // Basic sweep: 4 points from 0x100 in steps of 0x10.
    for (int i = 0; i < 4; i++) exp_tc_q.push_back(32'h100 + 32'(i) * 32'h10);
    start_sweep(32'h100, 32'h10, 4'd4);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_tc", bus.timing_control, 32'h100);
    tick(3);
    check("settle_not_early", 32'(bus.request_run), 32'd0);
    tick(1);
    check("first_run_latency", 32'(bus.request_run), 32'd1);
    wait_done("basic", 500);
    check("basic_points", 32'(bus.points_captured), 32'd4);
    check("basic_busy", 32'(bus.busy), 32'd0);
    check("basic_error", 32'(bus.error), 32'd0);
    check("basic_pulses_left", 32'(exp_tc_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) read_buf(i, 32'h100 + 32'(i) * 32'h10);
    read_end();

    // Phase wrap.
    exp_tc_q.push_back(32'hFFFF_FFF8);
    exp_tc_q.push_back(32'h0000_0000);
    start_sweep(32'hFFFF_FFF8, 32'h8, 4'd2);
    wait_done("wrap", 500);
    check("wrap_points", 32'(bus.points_captured), 32'd2);
    read_buf(0, 32'hFFFF_FFF8);
    read_buf(1, 32'h0000_0000);
    read_end();

    // Lock stall: run pulse only one cycle after lock rises.
    bus.locked = 1'b0;
    exp_tc_q.push_back(32'h500);
    start_sweep(32'h500, 32'h1, 4'd1);
    stray = 0;
    for (int i = 0; i < SETTLE + 1000; i++) begin
      @(negedge clk);
      if (bus.request_run === 1'b1) stray++;
    end
    check("stall_no_run", 32'(stray), 32'd0);
    bus.locked = 1'b1;
    @(negedge clk);
    check("run_one_after_lock", 32'(bus.request_run), 32'd1);
    wait_done("stall", 500);

    // Abort during WAIT of point 2 of 8.
    exp_tc_q.push_back(32'h1000);
    exp_tc_q.push_back(32'h1100);
    exp_tc_q.push_back(32'h1200);
    start_sweep(32'h1000, 32'h100, 4'd8);
    k = 0;
    while (bus.points_captured !== 4'd2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("abort_two_points", 32'(bus.points_captured), 32'd2);
    k = 0;
    while (bus.request_run !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_run_seen", 32'(bus.request_run), 32'd1);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_points", 32'(bus.points_captured), 32'd2);
    check("abort_tc_hold", bus.timing_control, 32'h1200);
    tick(20);
    check("late_result_ignored", 32'(bus.points_captured), 32'd2);
    for (int i = 0; i < 3; i++) exp_tc_q.push_back(32'h40 + 32'(i) * 32'h4);
    start_sweep(32'h40, 32'h4, 4'd3);
    wait_done("after_abort", 500);
    check("after_abort_points", 32'(bus.points_captured), 32'd3);
    for (int i = 0; i < 3; i++) read_buf(i, 32'h40 + 32'(i) * 32'h4);
    read_end();

    // Zero-point sweep: done next cycle, no run.
    start_sweep(32'h9999, 32'h1, 4'd0);
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    check("zero_points", 32'(bus.points_captured), 32'd0);
    tick(10);

    // Oversized count clamps to DEPTH.
    for (int i = 0; i < DEPTH; i++) exp_tc_q.push_back(32'(i));
    start_sweep(32'h0, 32'h1, 4'(DEPTH + 5));
    wait_done("clamp", 1500);
    check("clamp_points", 32'(bus.points_captured), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) read_buf(i, 32'(i));
    read_end();

    // Reset in the middle of a sweep.
    start_sweep(32'hABC, 32'h1, 4'd2);
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_tc", bus.timing_control, 32'd0);
    check("midrst_points", 32'(bus.points_captured), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_rd_data", bus.rd_data, 32'd0);
    reset = 1'b0;
    tick(2);

`ifdef ETS_SWEEP_TIMEOUT_EN
    // Silent sampler: each point times out and the sweep still advances.
    sampler_en = 1'b0;
    exp_tc_q.push_back(32'h77);
    exp_tc_q.push_back(32'h78);
    start_sweep(32'h77, 32'h1, 4'd2);
    wait_done("timeout", 1000);
    check("timeout_error", 32'(bus.error), 32'd1);
    check("timeout_points", 32'(bus.points_captured), 32'd2);
    read_buf(0, 32'hFFFF_FFFF);
    read_buf(1, 32'hFFFF_FFFF);
    read_end();
    sampler_en = 1'b1;
`endif

    tick(5);
    check("pulses_left", 32'(exp_tc_q.size()), 32'd0);
    check("reads_left", 32'(exp_rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ets_sweep_sequencer.md
# ets_sweep_sequencer

Sequences an equivalent-time sampling sweep across the ETS clock generator and the offset sampler. For each of N points it programs a phase word into the clock generator's timing control, waits for the clock to settle and lock, fires one sampler run, and captures the result into an on-chip buffer. The SPI register block configures it and reads the captured waveform back. This replaces per-point software pokes of the timing-control and control registers.

## Interface
Parameters:
- `DEPTH`, 64: result buffer entries; power of two. `AW` = log2(`DEPTH`).
- `SETTLE_CYCLES`, 256: minimum cycles to wait after a phase change before checking lock; must be at least 1.
- `TIMEOUT_CYCLES`, 2^20: limit on the wait for a sampler result. Used only when the timeout macro is defined.

Ports (`clk` is the single clock; reset is synchronous, active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a sweep.
- `abort` in 1: one-cycle pulse that cancels a sweep.
- `phase_start` in 32: phase word for point 0.
- `phase_step` in 32: increment added to the phase word between points.
- `step_count` in AW+1: number of points to capture.
- `timing_control` out 32: drives the clock generator's timing control input.
- `locked` in 1: clock generator lock indication.
- `request_run` out 1: one-cycle pulse to the sampler.
- `result_ready` in 1: sampler result strobe.
- `sampler_result` in 32: sampler result, valid with `result_ready`.
- `rd_addr` in AW: buffer read address.
- `rd_data` out 32: buffer read data.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: sticky; set when a sweep completes.
- `error` out 1: sticky timeout flag.
- `points_captured` out AW+1: number of points stored in the current sweep.

## Operation
- States: IDLE, SETTLE, RUN, WAIT.
- IDLE, on `start`:
  - Latch `phase_start`, `phase_step` and `step_count`. Counts above `DEPTH` are clamped to `DEPTH`.
  - Load `timing_control` with `phase_start`.
  - Clear index, `points_captured`, `done` and `error`.
  - Go to SETTLE.
- IDLE, on `start` with `step_count`==0: set `done`, stay in IDLE, store nothing.
- SETTLE:
  - The settle counter runs `SETTLE_CYCLES` cycles.
  - After that, wait for `locked`==1 with no limit.
  - Then go to RUN.
- RUN: assert `request_run` for exactly one cycle, then go to WAIT.
- WAIT, on `result_ready`:
  - Write `sampler_result` to buffer[index] and increment `points_captured`.
  - If index+1 equals the latched count: go to IDLE and set `done`.
  - Otherwise: `timing_control` += `phase_step` (modulo 2^32, wrap allowed), index++, go to SETTLE.
- `result_ready` outside WAIT is ignored.
- `start` while `busy` is ignored.
- `abort` in any non-IDLE state:
  - Return to IDLE next cycle; `busy`=0 and `done` stays 0.
  - `points_captured` and buffer contents are retained.
  - `timing_control` holds its last value.
- `abort` and `start` in the same IDLE cycle: `abort` has no effect; `start` proceeds.
- `abort` and `result_ready` in the same WAIT cycle: the result is stored, then the sweep aborts.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - State IDLE.
  - `timing_control`=0, `request_run`=0, `busy`=0, `done`=0, `error`=0, `points_captured`=0.
  - Buffer contents undefined.
  - `rd_data`=0.
- `start` in cycle t gives `busy`=1 at t+1, with `timing_control` already updated.
- With `locked` held high, `request_run` is high at cycle t+1+`SETTLE_CYCLES`.
- `result_ready` in cycle r:
  - Buffer write, `points_captured` update and `done` are all visible at r+1.
  - The next `timing_control` value is also visible at r+1.
- `rd_data` is registered with a one-cycle latency from `rd_addr`.
- A read of the address being written in the same cycle returns the old data.
- Reset mid-sweep: IDLE on the next cycle; all outputs return to their reset values.

## Configuration
- Macro `ETS_SWEEP_TIMEOUT_EN`.
- Defined: a WAIT counter starts on entry to WAIT.
  - If `TIMEOUT_CYCLES` elapse with no `result_ready`, store 32'hFFFFFFFF at buffer[index] and set `error`.
  - Then continue exactly as if a result had arrived.
- Undefined: WAIT has no limit. `error` is tied to 0, and no counter is synthesised.

## Structure
- Package `ets_sweep_pkg` holds:
  - the state enum `sweep_state_t`;
  - `TIMEOUT_SENTINEL` = 32'hFFFFFFFF;
  - the `STEP_COUNT_MAX` helper.
- Sub-module `ets_result_ram` is a simple dual-port RAM: one write port, one registered read port, `DEPTH`x32.
- The FSM, the settle/timeout counters and the phase accumulator live in the top module.

## Test plan
- Basic sweep:
  - Stimulus: `phase_start`=0x100, `phase_step`=0x10, `step_count`=4, `locked`=1, sampler model replying 5 cycles after `request_run` with result = phase.
  - Response: buffer reads 0x100/0x110/0x120/0x130; `done`=1; `points_captured`=4; exactly 4 `request_run` pulses.
- Phase wrap: `phase_start`=0xFFFFFFF8, `phase_step`=0x8, `step_count`=2 -> `timing_control` goes 0xFFFFFFF8 then 0x00000000.
- Lock stall: hold `locked`=0 for 1000 cycles after settle -> no `request_run` until `locked` rises; the pulse arrives exactly 1 cycle after lock.
- Abort: `abort` during WAIT of point 2 of 8 -> `busy`=0 next cycle, `done`=0, `points_captured`=2; a following `start` runs a complete sweep.
- Edge counts:
  - `step_count`=0 -> `done` the next cycle, no `request_run`.
  - `step_count`=DEPTH+5 -> exactly `DEPTH` points captured.
- Timeout (with `ETS_SWEEP_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, sampler silent) -> buffer[0]=0xFFFFFFFF, `error`=1, sweep continues to the next point.
